fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the `Asynch_FIFO` among `NUM_REQ` requesters in the write clock domain. It grants one requester at a time and holds the grant for a bounded burst. It forwards the owner's data to `write_data`/`write_inc` and back-pressures every requester from `write_full`. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATASIZE`, 8: word width; equals the FIFO `DATASIZE`.
- `MAX_BURST`, 4: maximum words per grant, 1..16.
- `write_clk` in 1: write-domain clock; all logic on its rising edge.
- `write_rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: requester i has a word pending.
- `req_data` in `NUM_REQ*DATASIZE`: flattened; requester i occupies bits `[i*DATASIZE +: DATASIZE]`.
- `req_ready` out `NUM_REQ`: word of requester i accepted this cycle.
- `write_full` in 1: FIFO full flag.
- `write_inc` out 1: FIFO write enable.
- `write_data` out `DATASIZE`: FIFO write data.
- `grant_id` out `$clog2(NUM_REQ)`: current owner index; valid only when `busy` is high.
- `busy` out 1: a grant is held.

## Operation
- FSM states are `IDLE` and `GRANT`.
- `IDLE`:
  - If any `req_valid` is high, pick a winner by round-robin. Search starts at `last_id+1` modulo `NUM_REQ`; the lowest index at or after that point wins.
  - Register the winner in `grant_id`, clear `burst_cnt`, and go to `GRANT`.
  - No transfer happens in `IDLE`.
- `GRANT`:
  - Transfer condition: `xfer = req_valid[grant_id] & ~write_full`.
  - Outputs, all combinational: `write_inc = xfer`, `req_ready[grant_id] = xfer`, and all other `req_ready` bits are 0.
  - `write_data` is the owner's `req_data` slice, driven even when `xfer` is 0.
  - On `xfer`, `burst_cnt` increments. `burst_cnt` width is `$clog2(MAX_BURST+1)`.
- Exit from `GRANT` to `IDLE`, with `last_id <= grant_id`, when either holds:
  - `xfer` occurs and `burst_cnt == MAX_BURST-1`, or
  - `req_valid[grant_id]` is low.
- `write_full` high only stalls: the grant is held and `burst_cnt` is frozen. A stall never ends a burst.
- Requesters may not retract `req_data` while `req_valid` is high and `req_ready` is low.
- Reset values:
  - State `IDLE`, `grant_id` 0, `last_id` `NUM_REQ-1` (so requester 0 wins first), `burst_cnt` 0.
  - Outputs: `write_inc` 0, `req_ready` 0, `busy` 0.
- `busy` is 1 exactly in `GRANT`.

## Timing
- Arbitration latency: 1 cycle. A request seen in `IDLE` can transfer at the earliest on the next edge's cycle.
- Peak throughput: `MAX_BURST` words per `MAX_BURST+1` cycles. The return to `IDLE` costs one bubble.
- `write_full` to `write_inc` is a combinational path, so no write is ever issued while full.
- Reset mid-burst: the next edge forces `IDLE` and the outputs drop to 0 in the same cycle. Words in flight are not replayed; requesters hold data until `req_ready`.
- Owner drops `req_valid` and another requester is valid on the same cycle: go to `IDLE`, then arbitrate on the following cycle.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `grant_count`, `NUM_REQ*16` bits, one 16-bit counter per requester.
  - A counter increments on each `IDLE`→`GRANT` award to that requester and saturates at 16'hFFFF.
  - Counters clear on `write_rst`.
- `FIFO_ARB_STATS_EN` undefined: the port and counters are absent; behaviour is otherwise identical.

## Structure
- Package `fifo_arb_pkg` holds:
  - `arb_state_t` (`IDLE`, `GRANT`);
  - `STAT_W = 16`;
  - the function computing `$clog2`-based index widths.
- Sub-module `rr_pick`: combinational round-robin priority picker with inputs `req`, `last_id` and outputs `any`, `winner`. Instantiated once.

## Test plan
- **Single requester burst:** `MAX_BURST=4`, req0 streams 0x11..0x16 with `write_full=0`.
  - 0x11–0x14 are written on consecutive cycles, then one bubble, then 0x15 and 0x16.
- **Fairness:** all four requesters valid continuously.
  - Grant order is 0,1,2,3,0; each receives exactly 4 writes per turn.
- **Full stall:** `write_full=1` for 5 cycles in mid-burst after 2 words.
  - No `write_inc` and no `req_ready` while full.
  - The grant is held, and the remaining 2 words are written after `write_full` drops.
- **Early release:** req2 drops `req_valid` after 1 word while req3 is valid.
  - `IDLE` for one cycle, then `grant_id=3`.
- **Reset mid-burst:** assert `write_rst` during the second word.
  - Next cycle: `busy=0`, `write_inc=0`, `req_ready=0`.
  - After release, requester 0 is granted first.
- **Stats (`FIFO_ARB_STATS_EN`):** after the fairness test runs for 3 rounds, every `grant_count` slice equals 3; the counter saturates at 0xFFFF under a forced long run.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Optional per-requester grant statistics are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned STAT_W = 16;

    // Index width for n requesters; never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester strictly after last_id
// (wrapping modulo NUM_REQ) wins; last_id itself has the lowest priority.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_id,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    logic w_found;

    always_comb begin
        any     = |req;
        winner  = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req[(32'(last_id) + k) % NUM_REQ]) begin
                winner  = IDX_W'((32'(last_id) + k) % NUM_REQ);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin bounded-burst arbiter in front of the Asynch_FIFO write port.
// Define FIFO_ARB_STATS_EN to add saturating per-requester grant counters.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATASIZE  = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                          write_clk,
    input  logic                          write_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATASIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          write_full,
    output logic                          write_inc,
    output logic [DATASIZE-1:0]           write_data,
    output logic [idx_width(NUM_REQ)-1:0] grant_id,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]     grant_count
`endif
);

    localparam int unsigned      IDX_W     = idx_width(NUM_REQ);
    localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] RST_LAST  = IDX_W'(NUM_REQ - 1);

    arb_state_t       r_state, w_state_next;
    logic [IDX_W-1:0] r_grant_id, w_grant_id_next;
    logic [IDX_W-1:0] r_last_id, w_last_id_next;
    logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_next;

    logic             w_any;
    logic [IDX_W-1:0] w_winner;
    logic             w_owner_valid;
    logic             w_xfer;
    logic             w_award;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_valid),
        .last_id (r_last_id),
        .any     (w_any),
        .winner  (w_winner)
    );

    assign w_owner_valid = req_valid[r_grant_id];
    // write_full gates the write combinationally so nothing is pushed into a full FIFO.
    assign w_xfer        = (r_state == GRANT) && w_owner_valid && !write_full;
    assign w_award       = (r_state == IDLE) && w_any;

    always_ff @(posedge write_clk) begin
        if (write_rst) begin
            r_state     <= IDLE;
            r_grant_id  <= '0;
            r_last_id   <= RST_LAST;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_grant_id  <= w_grant_id_next;
            r_last_id   <= w_last_id_next;
            r_burst_cnt <= w_burst_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_grant_id_next  = r_grant_id;
        w_last_id_next   = r_last_id;
        w_burst_cnt_next = r_burst_cnt;

        req_ready  = '0;
        write_inc  = w_xfer;
        write_data = req_data[r_grant_id*DATASIZE +: DATASIZE];
        grant_id   = r_grant_id;
        busy       = (r_state == GRANT);

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next     = GRANT;
                    w_grant_id_next  = w_winner;
                    w_burst_cnt_next = '0;
                end
            end
            GRANT: begin
                if (w_xfer) begin
                    req_ready[r_grant_id] = 1'b1;
                    w_burst_cnt_next      = r_burst_cnt + CNT_W'(1);
                end
                // A full stall holds the grant; only a finished burst or a dropped
                // request gives the port back.
                if ((w_xfer && (r_burst_cnt == LAST_BEAT)) || !w_owner_valid) begin
                    w_state_next   = IDLE;
                    w_last_id_next = r_grant_id;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [STAT_W-1:0] r_grant_cnt;

        always_ff @(posedge write_clk) begin
            if (write_rst) begin
                r_grant_cnt <= '0;
            end else if (w_award && (w_winner == IDX_W'(g)) && (r_grant_cnt != '1)) begin
                r_grant_cnt <= r_grant_cnt + STAT_W'(1);
            end
        end

        assign grant_count[g*STAT_W +: STAT_W] = r_grant_cnt;
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios then randomized traffic, each
// cycle compared against a transaction-level model of the arbitration rules.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic             write_clk = 1'b0;
    logic             write_rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             write_full;
    logic             write_inc;
    logic [DW-1:0]    write_data;
    logic [1:0]       grant_id;
    logic             busy;
`ifdef FIFO_ARB_STATS_EN
    logic [NR*16-1:0] grant_count;
`endif

    always #5 write_clk = ~write_clk;

    fifo_write_arbiter #(
        .NUM_REQ    (NR),
        .DATASIZE   (DW),
        .MAX_BURST  (MB)
    ) dut (
        .write_clk  (write_clk),
        .write_rst  (write_rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .write_full (write_full),
        .write_inc  (write_inc),
        .write_data (write_data),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    int vectors = 0;
    int errors  = 0;

    // Model: current owner (-1 = none), words moved this grant, previous owner.
    int            m_owner;
    int            m_words;
    int            m_last;
    int            m_stats [NR];
    logic [DW-1:0] seq [NR];

    logic [DW-1:0] log_q [$];
    int            grant_q [$];
    int            gw_q [$];
    logic          prev_busy = 1'b0;
    logic [31:0]   inc_hist  = '0;
    logic [31:0]   busy_hist = '0;
    logic [NR-1:0] rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_words = 0;
        m_last  = NR - 1;
        for (int i = 0; i < NR; i++) m_stats[i] = 0;
    endtask

    task automatic cycle(input logic rst, input logic [NR-1:0] vld, input logic full);
        logic          exp_xfer;
        logic [NR-1:0] exp_ready;
        write_rst  = rst;
        req_valid  = vld;
        write_full = full;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = seq[i];
        #4;
        exp_xfer  = (m_owner >= 0) && vld[m_owner] && !full;
        exp_ready = exp_xfer ? (NR'(1) << m_owner) : '0;
        chk("busy", busy, m_owner >= 0);
        chk("write_inc", write_inc, exp_xfer);
        chk("req_ready", req_ready, exp_ready);
        if (m_owner >= 0) begin
            chk("grant_id", grant_id, m_owner);
            chk("write_data", write_data, seq[m_owner]);
        end
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < NR; i++) chk("grant_count", grant_count[i*16 +: 16], m_stats[i]);
`endif
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            grant_q.push_back(int'(grant_id));
            gw_q.push_back(0);
        end
        if (write_inc === 1'b1) begin
            log_q.push_back(write_data);
            if (gw_q.size() > 0) gw_q[gw_q.size()-1]++;
        end
        prev_busy = busy;
        inc_hist  = {inc_hist[30:0], write_inc};
        busy_hist = {busy_hist[30:0], busy};

        if (exp_xfer) seq[m_owner]++;
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                if (m_owner < 0 && vld[(m_last + k) % NR]) begin
                    m_owner = (m_last + k) % NR;
                    m_words = 0;
                    if (m_stats[m_owner] < 65535) m_stats[m_owner]++;
                end
            end
        end else begin
            if (exp_xfer) m_words++;
            if ((exp_xfer && m_words == MB) || !vld[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        @(posedge write_clk);
        #1;
    endtask

    task automatic clear_logs();
        log_q.delete();
        grant_q.delete();
        gw_q.delete();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) seq[i] = DW'(8'h20 * i);
        seq[0]     = 8'h11;
        write_rst  = 1'b1;
        req_valid  = '0;
        write_full = 1'b0;
        req_data   = '0;
        repeat (2) @(posedge write_clk);
        #1;
        model_reset();

        // Reset state held
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0000, 1'b0);

        // Single requester: four words, one bubble, two more
        clear_logs();
        for (int c = 0; c < 8; c++) cycle(1'b0, {3'b000, seq[0] <= 8'h16}, 1'b0);
        chk("burst_pattern", inc_hist[7:0], 8'h7B);
        chk("burst_words", log_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("burst_data", log_q[i], 8'h11 + i);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);

        // Fairness: all requesters valid
        cycle(1'b1, 4'b0000, 1'b0);
        clear_logs();
        for (int c = 0; c < 25; c++) cycle(1'b0, 4'b1111, 1'b0);
        chk("fair_grants", grant_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("fair_order", grant_q[i], i % NR);
        for (int i = 0; i < 4; i++) chk("fair_words", gw_q[i], MB);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);

        // Full stall after two words
        cycle(1'b1, 4'b0000, 1'b0);
        clear_logs();
        for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0001, 1'b0);
        for (int c = 0; c < 5; c++) cycle(1'b0, 4'b0001, 1'b1);
        chk("stall_words", log_q.size(), 2);
        chk("stall_hold", busy, 1'b1);
        for (int c = 0; c < 2; c++) cycle(1'b0, 4'b0001, 1'b0);
        chk("stall_done", log_q.size(), 4);
        chk("stall_grants", grant_q.size(), 1);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);

        // Early release: req2 leaves after one word, req3 takes over after a gap
        cycle(1'b1, 4'b0000, 1'b0);
        clear_logs();
        cycle(1'b0, 4'b1100, 1'b0);
        cycle(1'b0, 4'b1100, 1'b0);
        for (int c = 0; c < 3; c++) cycle(1'b0, 4'b1000, 1'b0);
        chk("early_busy", busy_hist[4:0], 5'b01101);
        chk("early_grants", grant_q.size(), 2);
        chk("early_first", grant_q[0], 2);
        chk("early_second", grant_q[1], 3);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);

        // Reset during the second word
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0001, 1'b0);
        cycle(1'b0, 4'b0001, 1'b0);
        cycle(1'b1, 4'b0001, 1'b0);
        cycle(1'b1, 4'b0011, 1'b0);
        chk("rst_busy", busy_hist[0], 1'b0);
        chk("rst_inc", inc_hist[0], 1'b0);
        clear_logs();
        cycle(1'b0, 4'b0011, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        chk("rst_grants", grant_q.size(), 1);
        chk("rst_first", grant_q[0], 0);

        // Randomized traffic with sticky valids, random full and rare resets
        rv = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) if ($urandom_range(0, 7) == 0) rv[i] = ~rv[i];
            cycle($urandom_range(0, 199) == 0, rv, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
